// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage pipeline: EX operand forwarding selects and
// hazard controller FSM states.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select for EX, MEM result beats WB result, x0 never forwarded.
// Purely combinational, zero latency; no flow control.
module fwd_sel
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] r,
  input  logic [4:0] rd_m,
  input  logic       regwr_m,
  input  logic [4:0] rd_wb,
  input  logic       regwr_wb,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwr_m && (rd_m != 5'd0) && (rd_m == r)) begin
      sel = FWD_MEM;
    end else if (regwr_wb && (rd_wb != 5'd0) && (rd_wb == r)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use bubble, MEM-resolved redirect squash, EX forwarding, event counters.
// Enables/flushes/forward selects are combinational (0 latency); a load-use holds PC and IF_ID one cycle.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Resetn,
  input  logic [4:0]       Ra_ID,
  input  logic [4:0]       Rb_ID,
  input  logic [4:0]       Rd_EX,
  input  logic             RegWr_EX,
  input  logic             MemtoReg_EX,
  input  logic [4:0]       Rd_M,
  input  logic             RegWr_M,
  input  logic [4:0]       Rd_WB,
  input  logic             RegWr_WB,
  input  logic             Branch_M,
  input  logic             Zero_M,
  input  logic             Jump_M,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_m_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state, state_nxt;
  logic       redirect, lu, lu_stall;
  logic       bubble_ex;
  logic [4:0] Ra_EX, Rb_EX;
  logic [1:0] sel_a, sel_b;

  assign redirect = (Branch_M & Zero_M) | Jump_M;
  assign lu       = (state == RUN) & MemtoReg_EX & RegWr_EX & (Rd_EX != 5'd0)
                  & ((Rd_EX == Ra_ID) | (Rd_EX == Rb_ID));
  assign lu_stall  = lu & ~redirect;
  assign bubble_ex = redirect | lu_stall;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:      state_nxt = lu_stall ? LU_STALL : RUN;
      LU_STALL: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Reset forces the pipeline registers to hold bubbles until release.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_flush  = 1'b0;
    if (!Resetn) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_m_flush  = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_m_flush  = 1'b1;
    end else if (lu_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // A bubble entering EX carries x0 so it can never match a forwarding source.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      Ra_EX <= 5'd0;
      Rb_EX <= 5'd0;
    end else begin
      Ra_EX <= bubble_ex ? 5'd0 : Ra_ID;
      Rb_EX <= bubble_ex ? 5'd0 : Rb_ID;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  fwd_sel u_fwd_a (
    .r        (Ra_EX),
    .rd_m     (Rd_M),
    .regwr_m  (RegWr_M),
    .rd_wb    (Rd_WB),
    .regwr_wb (RegWr_WB),
    .sel      (sel_a)
  );

  fwd_sel u_fwd_b (
    .r        (Rb_EX),
    .rd_m     (Rd_M),
    .regwr_m  (RegWr_M),
    .rd_wb    (Rd_WB),
    .regwr_wb (RegWr_WB),
    .sel      (sel_b)
  );

  assign fwd_a = Resetn ? sel_a : FWD_RF;
  assign fwd_b = Resetn ? sel_b : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters so wrap is reachable.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Resetn;
  logic [4:0]       Ra_ID, Rb_ID, Rd_EX, Rd_M, Rd_WB;
  logic             RegWr_EX, MemtoReg_EX, RegWr_M, RegWr_WB;
  logic             Branch_M, Zero_M, Jump_M;
  logic             pc_en, if_id_en, if_id_flush, id_ex_flush, ex_m_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Resetn(Resetn),
    .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .Rd_EX(Rd_EX),
    .RegWr_EX(RegWr_EX), .MemtoReg_EX(MemtoReg_EX),
    .Rd_M(Rd_M), .RegWr_M(RegWr_M), .Rd_WB(Rd_WB), .RegWr_WB(RegWr_WB),
    .Branch_M(Branch_M), .Zero_M(Zero_M), .Jump_M(Jump_M),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_m_flush(ex_m_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    Ra_ID = 0; Rb_ID = 0; Rd_EX = 0; RegWr_EX = 0; MemtoReg_EX = 0;
    Rd_M = 0; RegWr_M = 0; Rd_WB = 0; RegWr_WB = 0;
    Branch_M = 0; Zero_M = 0; Jump_M = 0;
  endtask

  // Load in EX writing x5, consumer in ID reading x5 on operand A.
  task automatic set_lu();
    Rd_EX = 5; RegWr_EX = 1; MemtoReg_EX = 1; Ra_ID = 5; Rb_ID = 3;
  endtask

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_m_flush}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {27'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_m_flush}, {27'd0, exp});
  endtask

  initial begin
    clear_in();
    Resetn = 0;
    #3;
    chk_ctl("reset_ctl", 5'b00111);
    chk("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("reset_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    tick();
    Resetn = 1;
    chk_ctl("idle_ctl", 5'b11000);

    // Load-use: one bubble, then the load result comes from WB
    set_lu();
    chk_ctl("lu_ctl", 5'b00010);
    tick(); exp_stall++;
    chk("lu_cnt", {28'd0, stall_cnt}, exp_stall);
    chk("lu_state", {30'd0, dut.state}, 32'd1);
    Rd_EX = 0; RegWr_EX = 0; MemtoReg_EX = 0; Rd_M = 5; RegWr_M = 1;
    chk_ctl("lu_stall_nostall", 5'b11000);
    tick();
    Rd_M = 0; RegWr_M = 0; Rd_WB = 5; RegWr_WB = 1;
    #1;
    chk("lu_fwd_a_wb", {30'd0, fwd_a}, 32'd2);
    chk("lu_fwd_b_rf", {30'd0, fwd_b}, 32'd0);
    chk("lu_back_run", {30'd0, dut.state}, 32'd0);

    // Forwarding priority on operand B
    clear_in(); Rb_ID = 7; tick();
    Rd_M = 7; RegWr_M = 1; Rd_WB = 7; RegWr_WB = 1;
    #1;
    chk("fwd_prio_mem", {30'd0, fwd_b}, 32'd1);
    chk("fwd_a_x0", {30'd0, fwd_a}, 32'd0);
    RegWr_M = 0; #1;
    chk("fwd_wb_only", {30'd0, fwd_b}, 32'd2);
    Rb_ID = 0; tick();
    Rd_M = 0; Rd_WB = 0; RegWr_M = 1; RegWr_WB = 1; #1;
    chk("fwd_x0_never", {30'd0, fwd_b}, 32'd0);

    // Taken branch, not-taken branch, jump
    clear_in(); Ra_ID = 4; Rb_ID = 6; Branch_M = 1; Zero_M = 1;
    chk_ctl("br_ctl", 5'b11111);
    tick(); exp_flush++;
    chk("br_cnt", {28'd0, flush_cnt}, exp_flush);
    chk("br_shadow", {22'd0, dut.Ra_EX, dut.Rb_EX}, 32'd0);
    Zero_M = 0;
    chk_ctl("br_not_taken", 5'b11000);
    tick();
    chk("br_nt_shadow", {22'd0, dut.Ra_EX, dut.Rb_EX}, {22'd0, 5'd4, 5'd6});
    Branch_M = 0; Jump_M = 1;
    chk_ctl("jmp_ctl", 5'b11111);
    tick(); exp_flush++;
    chk("jmp_cnt", {28'd0, flush_cnt}, exp_flush);

    // Redirect and load-use together: redirect wins
    clear_in(); set_lu(); Jump_M = 1;
    chk_ctl("sim_ctl", 5'b11111);
    tick(); exp_flush++;
    chk("sim_stall_cnt", {28'd0, stall_cnt}, exp_stall);
    chk("sim_flush_cnt", {28'd0, flush_cnt}, exp_flush);
    chk("sim_state", {30'd0, dut.state}, 32'd0);

    // Redirect while in LU_STALL
    Jump_M = 0; tick(); exp_stall++;
    chk("lus_state", {30'd0, dut.state}, 32'd1);
    Branch_M = 1; Zero_M = 1;
    chk_ctl("lus_redirect_ctl", 5'b11111);
    tick(); exp_flush++;
    chk("lus_redirect_state", {30'd0, dut.state}, 32'd0);

    // Back-to-back load-use: RUN, LU_STALL, RUN, LU_STALL
    Branch_M = 0; Zero_M = 0;
    chk_ctl("b2b_stall1", 5'b00010);
    tick(); exp_stall++;
    chk_ctl("b2b_free", 5'b11000);
    tick();
    chk("b2b_run", {30'd0, dut.state}, 32'd0);
    chk_ctl("b2b_stall2", 5'b00010);
    tick(); exp_stall++;
    chk("b2b_cnt", {28'd0, stall_cnt}, exp_stall);
    tick();
    chk_ctl("b2b_stall3", 5'b00010);
    tick(); exp_stall++;
    chk("pre_rst_cnt", {28'd0, stall_cnt}, 32'd5);
    chk("pre_rst_state", {30'd0, dut.state}, 32'd1);

    // Asynchronous reset mid-operation
    Resetn = 0;
    chk_ctl("mid_rst_ctl", 5'b00111);
    chk("mid_rst_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    chk("mid_rst_state", {30'd0, dut.state}, 32'd0);
    tick();
    Resetn = 1;
    chk_ctl("post_rst_lu", 5'b00010);
    tick();
    chk("post_rst_cnt", {28'd0, stall_cnt}, 32'd1);

    // Flush counter wrap
    clear_in(); Jump_M = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_pre", {28'd0, flush_cnt}, 32'd15);
    tick();
    chk("wrap_zero", {28'd0, flush_cnt}, 32'd0);
    Jump_M = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
